simon_encrypt_controller: RTL and testbench
===========================================

SIMON_ENCRYPT_CONTROLLER -- requirements
Module: simon_encrypt_controller

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 32, meaning rounds per encryption; legal range 1..32.
REQ-002 SHALL have parameter OPCNT_W, default 16, meaning width of the completed-operation counter.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: plaintext and key request is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the controller accepts a request.
REQ-007 SHALL have port plaintext, input, 32 bits: plaintext block, sampled on accept.
REQ-008 SHALL have port key, input, 64 bits: key, sampled on accept.
REQ-009 SHALL have port out_valid, output, 1 bit: ciphertext result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port ciphertext, output, 32 bits: registered result.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port op_count, output, OPCNT_W bits: number of completed output handshakes.

Function
REQ-014 SHALL implement an FSM with states IDLE, LOAD, RUN, CAPTURE and DONE.
REQ-015 SHALL drive in_ready = (state == IDLE); no other state accepts a request.
REQ-016 SHALL, on in_valid && in_ready, register plaintext and key and go IDLE -> LOAD.
REQ-017 SHALL, in LOAD, drive core load=1 and core count=0 for exactly one cycle, then go to RUN with round counter = 0.
REQ-018 SHALL, in RUN, drive core load=0 and core count = round counter, incrementing by 1 per cycle.
REQ-019 SHALL go RUN -> CAPTURE on the edge where round counter == NUM_ROUNDS-1; round counter never exceeds NUM_ROUNDS-1 and never wraps.
REQ-020 SHALL, in CAPTURE, load the ciphertext register from the core output and go to DONE.
REQ-021 SHALL make out_valid high exactly NUM_ROUNDS+3 rising edges after the accept edge (35 for the default).
REQ-022 SHALL hold out_valid and ciphertext stable in DONE until out_ready is high; on out_valid && out_ready, increment op_count and go to IDLE.
REQ-023 SHALL not bypass: when out_ready is high in DONE, in_ready is still low that cycle, and a new accept is possible no earlier than the next cycle.
REQ-024 SHALL let op_count wrap modulo 2^OPCNT_W.
REQ-025 SHALL ignore changes on plaintext and key after accept; the captured copies drive the core.
REQ-026 SHALL keep core load low in every state other than LOAD.

Reset
REQ-027 SHALL, while rst is high, asynchronously force state=IDLE, round counter=0, ciphertext=0, op_count=0, out_valid=0, busy=0 and core load=0; in_ready=1 follows from IDLE.
REQ-028 SHALL, when rst is asserted mid-operation (LOAD, RUN, CAPTURE or DONE), abandon the operation with no output and no op_count increment.
REQ-029 SHALL accept a request on the first rising edge after rst deasserts.

Structure
REQ-030 SHALL place the state enum, NUM_ROUNDS default, and the block/key/count widths (32/64/5) in shared package simon_pkg.
REQ-031 SHALL instantiate exactly one sub-module, SIMON_iterative_cipher_core, driven with clk, rst, load, the captured plaintext and key, and count.
REQ-032 SHALL make all outputs registered, except in_ready and busy, which are decoded directly from state.

Verification
REQ-033 SHALL verify that plaintext 65656877 with key 1918111009080100 accepted produces ciphertext c69be9bb, with out_valid high 35 edges after accept.
REQ-034 SHALL verify that out_ready held low for 10 cycles in DONE leaves ciphertext c69be9bb and out_valid stable, and that op_count increments only at the handshake.
REQ-035 SHALL verify that back-to-back requests with in_valid held high see in_ready low in DONE on the handshake cycle, the second accept one cycle later, and each result matches its expected vector.
REQ-036 SHALL verify that rst pulsed in RUN at round 10 gives out_valid=0, op_count unchanged, and a following request still producing correct ciphertext.
REQ-037 SHALL verify that changing plaintext and key during RUN leaves the result equal to the vector captured at accept.
REQ-038 SHALL verify that with OPCNT_W=2, 5 completed operations give op_count = 1 (wrap).

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon32/64 encryption controller and its core.
package simon_pkg;

  localparam int BLOCK_W        = 32;
  localparam int KEY_W          = 64;
  localparam int CNT_W          = 5;
  localparam int WORD_W         = BLOCK_W / 2;
  localparam int NUM_ROUNDS_DEF = 32;

  // First 32 bits of the z0 constant sequence, element 0 leftmost.
  localparam logic [0:31] Z0_SEQ = 32'b11111010001001010110000111001101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  // Simon round function f(x) = (x<<<1 & x<<<8) ^ x<<<2.
  function automatic logic [WORD_W-1:0] simon_f(input logic [WORD_W-1:0] x);
    return ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]};
  endfunction

endpackage

// File: rtl/SIMON_iterative_cipher_core.sv
// One Simon32/64 round per clock with an on-the-fly key schedule; load seeds block and key.
module SIMON_iterative_cipher_core
  import simon_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [BLOCK_W-1:0] block_i,
  input  logic [KEY_W-1:0]   key_i,
  input  logic [CNT_W-1:0]   count_i,
  output logic [BLOCK_W-1:0] block_o
);

  logic [WORD_W-1:0]      x_q, x_d, y_q, y_d;
  logic [3:0][WORD_W-1:0] k_q, k_d;
  logic [WORD_W-1:0]      ks_t0, ks_t1, k_new;

  // k_q[0] is the current round key; k_new extends the schedule by one word (index count_i + 4).
  assign ks_t0 = {k_q[3][2:0], k_q[3][15:3]} ^ k_q[1];
  assign ks_t1 = ks_t0 ^ {ks_t0[0], ks_t0[15:1]};
  assign k_new = ~k_q[0] ^ ks_t1 ^ 16'h0003 ^ {15'b0, Z0_SEQ[count_i]};

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    k_d = k_q;
    if (load) begin
      x_d = block_i[31:16];
      y_d = block_i[15:0];
      k_d = key_i;
    end else begin
      x_d = y_q ^ simon_f(x_q) ^ k_q[0];
      y_d = x_q;
      k_d = {k_new, k_q[3], k_q[2], k_q[1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      k_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      k_q <= k_d;
    end
  end

  assign block_o = {x_q, y_q};

endmodule

// File: rtl/simon_encrypt_controller.sv
// Valid/ready wrapper sequencing one Simon32/64 encryption through the iterative core.
module simon_encrypt_controller
  import simon_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int OPCNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] plaintext,
  input  logic [KEY_W-1:0]   key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] ciphertext,
  output logic               busy,
  output logic [OPCNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   round_q, round_d;
  logic [BLOCK_W-1:0] pt_q, pt_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [BLOCK_W-1:0] ct_q, ct_d;
  logic [OPCNT_W-1:0] opcnt_q, opcnt_d;
  logic               out_valid_q, out_valid_d;
  logic               core_load;
  logic [CNT_W-1:0]   core_count;
  logic [BLOCK_W-1:0] core_block;

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    pt_d        = pt_q;
    key_d       = key_q;
    ct_d        = ct_q;
    opcnt_d     = opcnt_q;
    out_valid_d = out_valid_q;
    core_load   = 1'b0;
    core_count  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          pt_d    = plaintext;
          key_d   = key;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        core_load = 1'b1;
        round_d   = '0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        core_count = round_q;
        // Counter parks at the last round rather than wrapping.
        if (round_q == LAST_ROUND) state_d = ST_CAPTURE;
        else                       round_d = round_q + CNT_W'(1);
      end
      ST_CAPTURE: begin
        ct_d        = core_block;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          opcnt_d     = opcnt_q + OPCNT_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      round_q     <= '0;
      pt_q        <= '0;
      key_q       <= '0;
      ct_q        <= '0;
      opcnt_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      pt_q        <= pt_d;
      key_q       <= key_d;
      ct_q        <= ct_d;
      opcnt_q     <= opcnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  SIMON_iterative_cipher_core u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (core_load),
    .block_i (pt_q),
    .key_i   (key_q),
    .count_i (core_count),
    .block_o (core_block)
  );

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign out_valid  = out_valid_q;
  assign ciphertext = ct_q;
  assign op_count   = opcnt_q;

endmodule

// File: tb/tb_simon_encrypt_controller.sv
// Directed checks of the Simon32/64 controller; a second instance with OPCNT_W=2 shares the stimulus.
module tb_simon_encrypt_controller;

  localparam logic [31:0] PT_A = 32'h6565_6877;
  localparam logic [63:0] K_A  = 64'h1918_1110_0908_0100;
  localparam logic [31:0] CT_A = 32'hc69b_e9bb;
  localparam logic [31:0] PT_B = 32'h0123_4567;
  localparam logic [63:0] K_B  = 64'h0f0e_0d0c_0b0a_0908;
  // Edges from accept to out_valid, counting the accept edge itself as edge 1.
  localparam int LAT = 32 + 3;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [31:0] plaintext;
  logic [63:0] key;
  logic        in_ready, out_valid, busy;
  logic [31:0] ciphertext;
  logic [15:0] op_count;
  logic        in_ready2, out_valid2, busy2;
  logic [31:0] ciphertext2;
  logic [1:0]  op_count2;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  simon_encrypt_controller dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext), .busy(busy), .op_count(op_count)
  );

  simon_encrypt_controller #(.NUM_ROUNDS(32), .OPCNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .plaintext(plaintext), .key(key), .out_valid(out_valid2), .out_ready(out_ready),
    .ciphertext(ciphertext2), .busy(busy2), .op_count(op_count2)
  );

  function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  // Textbook Simon32/64: expand all round keys first, then run the rounds.
  function automatic logic [31:0] simon_ref(input logic [31:0] p, input logic [63:0] k);
    logic [15:0] ks [0:31];
    logic [61:0] zs;
    logic [15:0] x, y, t;
    zs = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) ks[i] = k[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = rotl(ks[i-1], 13) ^ ks[i-3];
      t = t ^ rotl(t, 15);
      ks[i] = ~ks[i-4] ^ t ^ 16'h0003 ^ {15'b0, zs[61-(i-4)]};
    end
    x = p[31:16];
    y = p[15:0];
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2) ^ ks[i];
      y = t;
    end
    return {x, y};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    $display("check %-28s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] p, input logic [63:0] k);
    plaintext = p;
    key       = k;
    in_valid  = 1'b1;
    chk("in_ready before accept", in_ready, 1'b1);
    tick();
    chk("busy after accept", busy, 1'b1);
    in_valid = 1'b0;
  endtask

  // Caller has already advanced `skip` edges beyond the accept edge.
  task automatic expect_result(input string tag, input logic [31:0] exp_ct, input int skip);
    repeat (LAT - 2 - skip) tick();
    chk({tag, " out_valid early"}, out_valid, 1'b0);
    tick();
    chk({tag, " out_valid at latency"}, out_valid, 1'b1);
    chk({tag, " ciphertext"}, ciphertext, exp_ct);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ct_b;
    ct_b      = simon_ref(PT_B, K_B);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    key       = '0;
    #12;
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset ciphertext", ciphertext, 32'h0);
    chk("reset op_count", op_count, 16'h0);
    rst = 1'b0;

    // Accept on the first edge after reset release, then abort at round 10.
    accept(PT_A, K_A);
    repeat (11) tick();
    rst = 1'b1;
    #1;
    chk("mid-run reset in_ready", in_ready, 1'b1);
    chk("mid-run reset busy", busy, 1'b0);
    chk("mid-run reset out_valid", out_valid, 1'b0);
    chk("mid-run reset op_count", op_count, 16'h0);
    rst = 1'b0;
    repeat (3) tick();
    chk("no output after abort", out_valid, 1'b0);

    // Basic vector.
    accept(PT_A, K_A);
    expect_result("op1", CT_A, 0);
    chk("op1 op_count pre-handshake", op_count, 16'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("op1 op_count", op_count, 16'h1);
    chk("op1 out_valid drop", out_valid, 1'b0);
    chk("op1 back to idle", in_ready, 1'b1);

    // Consumer stalls for 10 cycles in DONE.
    accept(PT_A, K_A);
    expect_result("op2", CT_A, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall out_valid", out_valid, 1'b1);
      chk("stall ciphertext", ciphertext, CT_A);
      chk("stall op_count", op_count, 16'h1);
    end
    out_ready = 1'b1;
    tick();
    chk("op2 op_count", op_count, 16'h2);

    // Back-to-back with in_valid held; new inputs after accept must be ignored by op3.
    accept(PT_A, K_A);
    in_valid  = 1'b1;
    plaintext = PT_B;
    key       = K_B;
    expect_result("op3", CT_A, 0);
    chk("op3 in_ready on handshake", in_ready, 1'b0);
    tick();
    chk("op3 op_count", op_count, 16'h3);
    chk("idle before second accept", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("second accept busy", busy, 1'b1);
    expect_result("op4", ct_b, 0);
    tick();
    chk("op4 op_count", op_count, 16'h4);

    // Inputs change during RUN; result follows the captured copy.
    out_ready = 1'b0;
    accept(PT_A, K_A);
    repeat (6) tick();
    plaintext = 32'hdead_beef;
    key       = 64'h0123_4567_89ab_cdef;
    expect_result("op5", CT_A, 6);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("op5 op_count", op_count, 16'h5);
    chk("wrap op_count OPCNT_W=2", op_count2, 2'd1);
    chk("wrap instance ciphertext", ciphertext2, CT_A);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
